// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Holds the CLA group size, the result-flag struct and the signed saturation limit function.
package addsub_pkg;

    localparam int unsigned CLA_GROUP = 4;
    localparam int unsigned MAX_WIDTH = 256;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // Most positive (negative=0) or most negative (negative=1) value of a signed word of 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] sat_limit(input int unsigned width,
                                                       input logic negative);
        logic [MAX_WIDTH-1:0] lim;
        lim = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i + 1 < width) begin
                lim[i] = ~negative;
            end else if (i + 1 == width) begin
                lim[i] = negative;
            end
        end
        return lim;
    endfunction

endpackage

// File: rtl/addsub_pipe_cla.sv
// 4-bit carry-lookahead group: propagate/generate, all internal carries in parallel,
// sum bits and group carry-out.
module cla_group
    import addsub_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 cin,
    output logic [CLA_GROUP-1:0] s,
    output logic                 cout
);

    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] g;
    logic [CLA_GROUP:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[CLA_GROUP-1:0];
    assign cout = c[CLA_GROUP];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one WIDTH/STAGES slice added per stage,
// carries registered between stages. Define ADDSUB_SATURATE_EN to clamp on signed overflow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned GPS  = SW / CLA_GROUP;
    localparam int unsigned LAST = STAGES - 1;

    if ((WIDTH % (CLA_GROUP * STAGES)) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $fatal(1, "addsub_pipe: WIDTH must be a multiple of 4*STAGES and at most MAX_WIDTH");
    end

    // Rank k holds the operands, partial sum and carry-in for stage k.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;

    logic [SW-1:0]     slice_sum [STAGES];
    logic [STAGES-1:0] slice_cout;
    logic [WIDTH-1:0]  s_nx      [STAGES];

    logic [WIDTH-1:0]  res;
    flags_t            flags_d;
    flags_t            flags_q;
    logic [WIDTH-1:0]  sum_q;
    logic              out_valid_q;
    logic              adv;
    logic              a_msb;
    logic              b_msb;
    logic              c_msb_in;
`ifdef ADDSUB_SATURATE_EN
    logic [MAX_WIDTH-1:0] lim;
`endif

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [GPS:0]  gc;
        logic [SW-1:0] gs;

        assign gc[0] = c_q[k];

        for (genvar g = 0; g < GPS; g++) begin : g_grp
            cla_group u_cla (
                .a    (a_q[k][k*SW + g*CLA_GROUP +: CLA_GROUP]),
                .b    (b_q[k][k*SW + g*CLA_GROUP +: CLA_GROUP]),
                .cin  (gc[g]),
                .s    (gs[g*CLA_GROUP +: CLA_GROUP]),
                .cout (gc[g+1])
            );
        end

        assign slice_sum[k]  = gs;
        assign slice_cout[k] = gc[GPS];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k] = s_q[k];
            s_nx[k][k*SW +: SW] = slice_sum[k];
        end
    end

    // Final stage: overflow from carry into vs. out of the MSB, optional clamp, then flags.
    always_comb begin
        a_msb         = a_q[LAST][WIDTH-1];
        b_msb         = b_q[LAST][WIDTH-1];
        res           = s_nx[LAST];
        c_msb_in      = res[WIDTH-1] ^ a_msb ^ b_msb;
        flags_d.cout  = slice_cout[LAST];
        flags_d.ovf   = c_msb_in ^ slice_cout[LAST];
`ifdef ADDSUB_SATURATE_EN
        lim = sat_limit(WIDTH, a_msb);
        if (flags_d.ovf) begin
            res = lim[WIDTH-1:0];
        end
`endif
        flags_d.zero = (res == '0);
        flags_d.neg  = res[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            a_q[0] <= a;
            b_q[0] <= sub ? ~b : b;
            c_q[0] <= cin ^ sub;
            s_q[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                s_q[k] <= s_nx[k-1];
                c_q[k] <= slice_cout[k-1];
            end
            out_valid_q <= v_q[LAST];
            if (v_q[LAST]) begin
                sum_q   <= res;
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=16, STAGES=4); honours ADDSUB_SATURATE_EN.
module tb_addsub_pipe;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    int   last_acc = 0;

    addsub_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic si, input logic ci);
        logic [W-1:0] be;
        logic [W:0]   full;
        exp_t         e;
        be     = si ? ~bi : bi;
        full   = {1'b0, ai} + {1'b0, be} + {{W{1'b0}}, ci ^ si};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ai[W-1] == be[W-1]) && (e.sum[W-1] != ai[W-1]);
`ifdef ADDSUB_SATURATE_EN
        if (e.ovf) e.sum = ai[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.zero = (e.sum == '0);
        e.neg  = e.sum[W-1];
        return e;
    endfunction

    // Handshakes are sampled at the negedge; inputs only change just after a posedge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sum",  32'(sum),  32'(mon_e.sum));
                    check_eq("cout", 32'(cout), 32'(mon_e.cout));
                    check_eq("ovf",  32'(ovf),  32'(mon_e.ovf));
                    check_eq("zero", 32'(zero), 32'(mon_e.zero));
                    check_eq("neg",  32'(neg),  32'(mon_e.neg));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, sub, cin));
        end
    end

    task automatic send(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic si, input logic ci);
        int waited = 0;
        in_valid = 1'b1;
        a = ai;
        b = bi;
        sub = si;
        cin = ci;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_out(output int lat);
        int waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!out_valid) check_eq("out_timeout", 32'(out_valid), 32'd1);
        lat = cyc - last_acc;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           lat;
        int           n_out0;
        int           stale;
        logic [W-1:0] held;
        logic [W-1:0] va [6] = '{16'h7FFF, 16'hFFFF, 16'h0003, 16'h0003, 16'h8000, 16'h1234};
        logic [W-1:0] vb [6] = '{16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'hFFFF, 16'h1234};
        logic         vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        cin = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum",       32'(sum),       32'd0);
        check_eq("rst_cout",      32'(cout),      32'd0);
        check_eq("rst_ovf",       32'(ovf),       32'd0);
        check_eq("rst_zero",      32'(zero),      32'd0);
        check_eq("rst_neg",       32'(neg),       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_eq("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Latency of a single add
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0002, 1'b0, 1'b0);
        idle();
        wait_out(lat);
        check_eq("latency", 32'(lat), 32'(S));
        drain();

        // Directed overflow / carry / borrow / zero cases, back to back
        for (int i = 0; i < 6; i++) send(va[i], vb[i], vs[i], vc[i]);
        idle();
        drain();

        // Backpressure: 8 back-to-back adds with a 5-cycle output stall
        n_out0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(W'(i), 16'h0100, 1'b0, 1'b0);
                idle();
            end
            begin
                int w = 0;
                while (!out_valid && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check_eq("bp_out_valid_seen", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                held = sum;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("stall_in_ready",  32'(in_ready),  32'd0);
                    check_eq("stall_out_valid", 32'(out_valid), 32'd1);
                    check_eq("stall_sum_hold",  32'(sum),       32'(held));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_count", 32'(n_out - n_out0), 32'd8);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("no_stale_result", 32'(stale), 32'd0);
        @(posedge clk);
        #1;
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
        idle();
        wait_out(lat);
        check_eq("latency_after_reset", 32'(lat), 32'(S));
        drain();

        // Random traffic with random output backpressure
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                idle();
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
